// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: captures the retiring instruction, waits for slow RAM loads
// (stalling upstream), and presents a one-cycle commit on the register-file write port.
// Optional forwarding outputs are built when MEM_WB_BYPASS_EN is defined; otherwise the
// bypass ports are tied to zero.
module mem_wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memValid,
  input  logic [3:0]  memRegIndex,
  input  logic [1:0]  memSrcSel,
  input  logic [15:0] memAluResult,
  input  logic [15:0] memPcPlus1,
  input  logic        memTWrite,
  input  logic        memTValue,
  input  logic [15:0] ramData,
  input  logic        ramReady,
  input  logic        flush,
  output logic [3:0]  writeIndex,
  output logic [15:0] dataToWrite,
  output logic        tWriteEnable,
  output logic        tToWrite,
  output logic        wbStall,
  output logic        loadError,
  output logic [15:0] retiredCount,
  output logic        bypassValid,
  output logic [3:0]  bypassIndex,
  output logic [15:0] bypassData
);

  typedef enum logic [1:0] {StIdle, StWaitLoad, StCommit} stateT;

  // Last wait-counter value before a stuck load is force-completed.
  localparam logic [7:0] TimeoutLast = 8'(LOAD_TIMEOUT - 1);

  stateT       stateQ, stateD;
  logic [3:0]  idxQ, idxD;
  logic        tWriteQ, tWriteD;
  logic        pendTValQ, pendTValD;   // T value of a load still waiting for RAM
  logic [15:0] dataQ, dataD;           // only updated on entry to COMMIT, so it holds outside
  logic        tValQ, tValD;           // likewise
  logic [7:0]  waitCntQ, waitCntD;
  logic        loadErrQ, loadErrD;
  logic [15:0] retiredQ, retiredD;

  // Next-state and capture logic.
  always_comb begin
    stateD    = stateQ;
    idxD      = idxQ;
    tWriteD   = tWriteQ;
    pendTValD = pendTValQ;
    dataD     = dataQ;
    tValD     = tValQ;
    waitCntD  = waitCntQ;
    loadErrD  = loadErrQ;
    retiredD  = (stateQ == StCommit) ? retiredQ + 16'd1 : retiredQ;

    case (stateQ)
      StWaitLoad: begin
        if (flush) begin
          stateD = StIdle;
        end else if (ramReady) begin
          stateD = StCommit;
          dataD  = ramData;
          tValD  = pendTValQ;
        end else if (waitCntQ == TimeoutLast) begin
          stateD   = StCommit;
          dataD    = 16'hFFFF;
          tValD    = pendTValQ;
          loadErrD = 1'b1;
        end else begin
          waitCntD = waitCntQ + 8'd1;
        end
      end
      default: begin
        // IDLE and COMMIT both accept a new instruction; a commit in progress is never
        // cancelled by flush, only the capture at this edge is.
        if (flush || !memValid) begin
          stateD = StIdle;
        end else begin
          idxD    = memRegIndex;
          tWriteD = memTWrite;
          if (memSrcSel == 2'b01 && !ramReady) begin
            stateD    = StWaitLoad;
            waitCntD  = 8'd0;
            pendTValD = memTValue;
          end else begin
            stateD = StCommit;
            tValD  = memTValue;
            case (memSrcSel)
              2'b01:   dataD = ramData;
              2'b10:   dataD = memPcPlus1;
              default: dataD = memAluResult;
            endcase
          end
        end
      end
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ    <= StIdle;
      idxQ      <= 4'd0;
      tWriteQ   <= 1'b0;
      pendTValQ <= 1'b0;
      dataQ     <= 16'd0;
      tValQ     <= 1'b0;
      waitCntQ  <= 8'd0;
      loadErrQ  <= 1'b0;
      retiredQ  <= 16'd0;
    end else begin
      stateQ    <= stateD;
      idxQ      <= idxD;
      tWriteQ   <= tWriteD;
      pendTValQ <= pendTValD;
      dataQ     <= dataD;
      tValQ     <= tValD;
      waitCntQ  <= waitCntD;
      loadErrQ  <= loadErrD;
      retiredQ  <= retiredD;
    end
  end

  logic committing;
  assign committing = (stateQ == StCommit);

  assign writeIndex   = committing ? idxQ : 4'd0;
  assign dataToWrite  = dataQ;
  assign tWriteEnable = committing ? ~tWriteQ : 1'b1;
  assign tToWrite     = tValQ;
  assign wbStall      = (stateQ == StWaitLoad);
  assign loadError    = loadErrQ;
  assign retiredCount = retiredQ;

`ifdef MEM_WB_BYPASS_EN
  assign bypassValid = committing && (idxQ != 4'd0);
  assign bypassIndex = committing ? idxQ : 4'd0;
  assign bypassData  = committing ? dataQ : 16'd0;
`else
  assign bypassValid = 1'b0;
  assign bypassIndex = 4'd0;
  assign bypassData  = 16'd0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_wb_stage;

  localparam int unsigned LoadTimeout = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memValid;
  logic [3:0]  memRegIndex;
  logic [1:0]  memSrcSel;
  logic [15:0] memAluResult;
  logic [15:0] memPcPlus1;
  logic        memTWrite;
  logic        memTValue;
  logic [15:0] ramData;
  logic        ramReady;
  logic        flush;
  logic [3:0]  writeIndex;
  logic [15:0] dataToWrite;
  logic        tWriteEnable;
  logic        tToWrite;
  logic        wbStall;
  logic        loadError;
  logic [15:0] retiredCount;
  logic        bypassValid;
  logic [3:0]  bypassIndex;
  logic [15:0] bypassData;

  always #5 clk = ~clk;

  mem_wb_stage #(.LOAD_TIMEOUT(LoadTimeout)) dut (
    .clk          (clk),
    .rst          (rst),
    .memValid     (memValid),
    .memRegIndex  (memRegIndex),
    .memSrcSel    (memSrcSel),
    .memAluResult (memAluResult),
    .memPcPlus1   (memPcPlus1),
    .memTWrite    (memTWrite),
    .memTValue    (memTValue),
    .ramData      (ramData),
    .ramReady     (ramReady),
    .flush        (flush),
    .writeIndex   (writeIndex),
    .dataToWrite  (dataToWrite),
    .tWriteEnable (tWriteEnable),
    .tToWrite     (tToWrite),
    .wbStall      (wbStall),
    .loadError    (loadError),
    .retiredCount (retiredCount),
    .bypassValid  (bypassValid),
    .bypassIndex  (bypassIndex),
    .bypassData   (bypassData)
  );

  int nTests = 0;
  int nFail  = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: an instruction is either absent, waiting for RAM (with the number of
  // wait cycles spent so far), or committing. The committed record persists afterwards.
  int          mMode;      // 0 none, 1 waiting, 2 committing
  int          mWaited;
  logic [3:0]  pIdx;
  logic        pTW, pTV;
  logic [3:0]  cIdx;
  logic        cTW, cTV;
  logic [15:0] cData;
  logic        mErr;
  logic [15:0] mCount;

  task automatic modelReset();
    mMode = 0; mWaited = 0;
    pIdx = 0; pTW = 0; pTV = 0;
    cIdx = 0; cTW = 0; cTV = 0; cData = 0;
    mErr = 0; mCount = 0;
  endtask

  task automatic commitPending(input logic [15:0] d);
    mMode = 2; cIdx = pIdx; cTW = pTW; cTV = pTV; cData = d;
  endtask

  // One rising edge, evaluated on the inputs present at that edge.
  task automatic modelEdge();
    if (mMode == 2) mCount = mCount + 16'd1;
    if (mMode == 1) begin
      if (flush) mMode = 0;
      else if (ramReady) commitPending(ramData);
      else if (mWaited == int'(LoadTimeout)) begin
        commitPending(16'hFFFF);
        mErr = 1'b1;
      end else mWaited++;
    end else if (flush || !memValid) begin
      mMode = 0;
    end else begin
      pIdx = memRegIndex; pTW = memTWrite; pTV = memTValue;
      if (memSrcSel == 2'd1 && !ramReady) begin
        mMode = 1; mWaited = 1;
      end else if (memSrcSel == 2'd1) commitPending(ramData);
      else if (memSrcSel == 2'd2) commitPending(memPcPlus1);
      else commitPending(memAluResult);
    end
  endtask

  task automatic checkOutputs();
    bit c;
    c = (mMode == 2);
    checkEq("writeIndex",   32'(writeIndex),   32'(c ? cIdx : 4'd0));
    checkEq("dataToWrite",  32'(dataToWrite),  32'(cData));
    checkEq("tWriteEnable", 32'(tWriteEnable), 32'(c ? !cTW : 1'b1));
    checkEq("tToWrite",     32'(tToWrite),     32'(cTV));
    checkEq("wbStall",      32'(wbStall),      32'(mMode == 1));
    checkEq("loadError",    32'(loadError),    32'(mErr));
    checkEq("retiredCount", 32'(retiredCount), 32'(mCount));
`ifdef MEM_WB_BYPASS_EN
    checkEq("bypassValid",  32'(bypassValid),  32'(c && cIdx != 4'd0));
    checkEq("bypassIndex",  32'(bypassIndex),  32'(c ? cIdx : 4'd0));
    checkEq("bypassData",   32'(bypassData),   32'(c ? cData : 16'd0));
`else
    checkEq("bypassValid",  32'(bypassValid),  32'd0);
    checkEq("bypassIndex",  32'(bypassIndex),  32'd0);
    checkEq("bypassData",   32'(bypassData),   32'd0);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutputs();
  endtask

  task automatic drive(input logic v, input logic [3:0] idx, input logic [1:0] sel,
                       input logic [15:0] alu, input logic [15:0] pc, input logic tw,
                       input logic tv, input logic [15:0] rd, input logic rdy, input logic fl);
    memValid = v; memRegIndex = idx; memSrcSel = sel; memAluResult = alu; memPcPlus1 = pc;
    memTWrite = tw; memTValue = tv; ramData = rd; ramReady = rdy; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic asyncReset();
    rst = 1'b0;
    #1;
    modelReset();
    checkOutputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    modelReset();
    #12;
    checkOutputs();
    @(negedge clk);
    rst = 1'b1;

    // ALU write to R3.
    drive(1, 3, 2'b00, 16'h1234, 16'h0007, 0, 0, 16'h5555, 0, 0);
    cycle();
    checkEq("alu.index", 32'(writeIndex), 32'd3);
    checkEq("alu.data", 32'(dataToWrite), 32'h1234);
    checkEq("alu.stall", 32'(wbStall), 32'd0);
    idle();
    cycle();
    checkEq("alu.retired", 32'(retiredCount), 32'd1);

    // Load to SP with two wait cycles.
    drive(1, 9, 2'b01, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0);
    cycle();
    cycle();
    checkEq("load.stall2", 32'(wbStall), 32'd1);
    ramReady = 1; ramData = 16'hBEEF;
    cycle();
    checkEq("load.index", 32'(writeIndex), 32'd9);
    checkEq("load.data", 32'(dataToWrite), 32'hBEEF);
    idle();
    cycle();

    // Timeout: RAM never answers.
    drive(1, 5, 2'b01, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < int'(LoadTimeout); i++) cycle();
    checkEq("timeout.stall", 32'(wbStall), 32'd1);
    cycle();
    checkEq("timeout.data", 32'(dataToWrite), 32'hFFFF);
    checkEq("timeout.error", 32'(loadError), 32'd1);
    idle();
    cycle();
    cycle();
    checkEq("timeout.sticky", 32'(loadError), 32'd1);

    // Flush on the second wait cycle.
    drive(1, 2, 2'b01, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0);
    cycle();
    cycle();
    flush = 1;
    cycle();
    checkEq("flush.index", 32'(writeIndex), 32'd0);
    checkEq("flush.retired", 32'(retiredCount), 32'd3);
    idle();
    cycle();

    // Link write to RA with T.
    drive(1, 10, 2'b10, 16'h9999, 16'h0041, 1, 1, 16'h0, 0, 0);
    cycle();
    checkEq("link.index", 32'(writeIndex), 32'd10);
    checkEq("link.data", 32'(dataToWrite), 32'h0041);
    checkEq("link.twe", 32'(tWriteEnable), 32'd0);
    checkEq("link.t", 32'(tToWrite), 32'd1);
    idle();
    cycle();
    checkEq("link.twe_off", 32'(tWriteEnable), 32'd1);

    // Randomized traffic, with the occasional asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      if (mMode == 1) begin
        ramData  = 16'($urandom);
        ramReady = ($urandom_range(3) == 0);
        flush    = ($urandom_range(9) == 0);
      end else begin
        drive($urandom_range(3) != 0, 4'($urandom_range(10)), 2'($urandom),
              16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
              16'($urandom), $urandom_range(2) == 0, $urandom_range(7) == 0);
      end
      cycle();
      if ($urandom_range(199) == 0) begin
        #2;
        asyncReset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline stage of the 16-bit CPU, directly upstream of the register file. It captures the retiring instruction from the MEM stage and selects the write-back value: ALU result, load data, or PC+1. It waits for slow RAM loads, stalling the pipeline while it waits, and presents a single-cycle commit on the register file's write port (`writeIndex`, `dataToWrite`, `tWriteEnable`, `tToWrite`), which the register file samples on the falling clock edge.

## Interface
- `LOAD_TIMEOUT`, default 15: maximum number of WAIT_LOAD cycles before a load is force-completed (1..255).
- `clk`  in  1  system clock; state advances on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `memValid`  in  1  the MEM stage holds an instruction to retire.
- `memRegIndex`  in  4  destination register: 1..7 = R1..R7, 8 = IH, 9 = SP, 10 = RA; 0 = no register write.
- `memSrcSel`  in  2  write-back source: 00 = ALU, 01 = load, 10 = PC+1, 11 = treated as ALU.
- `memAluResult`  in  16  ALU result.
- `memPcPlus1`  in  16  PC+1, used for link writes.
- `memTWrite`  in  1  the instruction writes T.
- `memTValue`  in  1  the T value to write.
- `ramData`  in  16  load data from RAM.
- `ramReady`  in  1  `ramData` is valid this cycle.
- `flush`  in  1  synchronous flush.
- `writeIndex`  out  4  register-file write index; 0 = no write.
- `dataToWrite`  out  16  register-file write data.
- `tWriteEnable`  out  1  active-low T write enable.
- `tToWrite`  out  1  T value to write.
- `wbStall`  out  1  hold the upstream stages.
- `loadError`  out  1  sticky flag: a load timed out.
- `retiredCount`  out  16  count of committed instructions; wraps.
- `bypassValid`  out  1  forwarding data is valid.
- `bypassIndex`  out  4  forwarding destination register.
- `bypassData`  out  16  forwarding data.

## Operation
- States: IDLE, WAIT_LOAD, COMMIT. All outputs are decoded from registered state and registered data only; there are no combinational paths from inputs to outputs.
- IDLE or COMMIT, rising edge:
  - `flush` high, or `memValid` low → IDLE.
  - Otherwise capture index, source, T fields and PC+1/ALU data.
  - If `memSrcSel`=01 and `ramReady` is low → WAIT_LOAD, wait counter = 0.
  - Otherwise → COMMIT. The data is `ramData` for a load, `memPcPlus1` for 10, and `memAluResult` for all other selects.
- WAIT_LOAD, rising edge (checked in this priority order):
  - `flush` → IDLE. The load is discarded and nothing is written.
  - `ramReady` → COMMIT with data = `ramData`.
  - Counter = `LOAD_TIMEOUT`-1 → COMMIT with data = 16'hFFFF; set `loadError`.
  - Otherwise increment the counter.
- In WAIT_LOAD, the `mem*` inputs are ignored. Upstream must hold them stable while `wbStall` is high.
- COMMIT drives `writeIndex` = the captured index and `dataToWrite` = the captured data. `tWriteEnable` = 0 iff the captured `memTWrite` is set; `tToWrite` = the captured T value.
- Outside COMMIT: `writeIndex` = 0, `tWriteEnable` = 1, `dataToWrite` and `tToWrite` hold their last values.
- A captured index of 0 still commits: `retiredCount` increments, but the register file sees no register write.
- `wbStall` = (state == WAIT_LOAD).
- `flush` during COMMIT does not cancel that commit; it only affects the capture at the following edge.
- `retiredCount` increments by 1, modulo 2^16, on each rising edge that leaves COMMIT.
- `loadError` is cleared only by reset.

## Timing
- Reset values: state IDLE; `writeIndex` 0; `dataToWrite` 0; `tWriteEnable` 1; `tToWrite` 0; `wbStall` 0; `loadError` 0; `retiredCount` 0; bypass outputs 0; wait counter 0.
- Reset asserted mid-load or mid-commit aborts immediately; no write occurs.
- Non-stalled latency: capture at rising edge N. The commit is visible from N to N+1, and the register file writes at the falling edge in between.
- Load latency: k cycles of `ramReady` low gives k WAIT_LOAD cycles and k cycles of `wbStall`, then one COMMIT cycle.
- Timeout: exactly `LOAD_TIMEOUT` WAIT_LOAD cycles, then COMMIT.
- Back-to-back: a new capture on the edge that leaves COMMIT gives consecutive COMMIT cycles with no bubble.

## Configuration
- `MEM_WB_BYPASS_EN` defined:
  - During COMMIT: `bypassValid` = (captured index ≠ 0), `bypassIndex` = captured index, `bypassData` = captured data.
  - Otherwise: `bypassValid` = 0.
- `MEM_WB_BYPASS_EN` undefined:
  - The bypass ports remain present and are tied to 0.
  - No bypass logic is synthesised.

## Test plan
- ALU write: reset, then `memValid`=1, index 3, sel 00, ALU 16'h1234 → next cycle `writeIndex`=3, `dataToWrite`=16'h1234, `wbStall`=0, `retiredCount`=1 after the following edge.
- Load with 2 wait cycles: sel 01, index 9, `ramReady` low for 2 edges then high with 16'hBEEF → `wbStall` high 2 cycles, then COMMIT with SP=16'hBEEF.
- Timeout: `LOAD_TIMEOUT`=4, `ramReady` never high → 4 stall cycles, then commit 16'hFFFF; `loadError`=1 and stays 1.
- Flush in WAIT_LOAD: flush on the 2nd wait cycle → IDLE, `writeIndex` stays 0, `retiredCount` unchanged.
- T and link: sel 10, index 10, PC+1 16'h0041, `memTWrite`=1, `memTValue`=1 → `writeIndex`=10, data 16'h0041, `tWriteEnable`=0, `tToWrite`=1 for exactly one cycle.
- Bypass build: with `MEM_WB_BYPASS_EN`, `bypassValid`=1/index 3/data 16'h1234 in the first scenario. Without it, all bypass ports stay 0.
